infer_check_ctrl: RTL and testbench

//  Sequencer for board-level MNIST inference checks. Repeatedly starts the network,

---
 rtl/infer_check_ctrl_if.sv | 26 ++
 rtl/infer_check_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_infer_check_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/infer_check_ctrl_if.sv
// ---------------------------------------------------------------------------
// infer_check_ctrl_if
//   Start/done handshake and result bus between the inference check
//   sequencer and the network core.
//   net_start : 1-cycle start pulse, sequencer -> network
//   net_done  : 1-cycle completion pulse, network -> sequencer
//   net_dout  : 80-bit network result, valid while net_done is high
//   Modports: master (sequencer side), slave (network side).
// ---------------------------------------------------------------------------
interface infer_check_ctrl_if;
    logic        net_start;
    logic        net_done;
    logic [79:0] net_dout;

    modport master (
        output net_start,
        input  net_done,
        input  net_dout
    );

    modport slave (
        input  net_start,
        output net_done,
        output net_dout
    );
endinterface

// File: rtl/infer_check_ctrl.sv
// ---------------------------------------------------------------------------
// infer_check_ctrl
//   Board-level MNIST inference check sequencer. Starts the network, waits for
//   completion under a watchdog, compares the 80-bit result to GOLDEN and shows
//   the outcome on two active-low LEDs for HOLD_CYCLES, then idles GAP_CYCLES
//   before the next run. Saturating pass/fail counters are kept for debug.
//
//   Ports:
//     clk           clock
//     rst_n         synchronous active-low reset
//     enable        run checks back-to-back (sampled in IDLE/GAP only)
//     net           network handshake (master modport: net_start out,
//                   net_done/net_dout in)
//     led_pass      active-low, lit during SHOW after a pass
//     led_fail      active-low, lit during SHOW after a fail or timeout
//     last_timeout  most recent completed run ended by the watchdog
//     pass_cnt      passes since reset, saturating
//     fail_cnt      fails + timeouts since reset, saturating
//
//   Build option: define FAIL_BLINK_EN to blink led_fail during SHOW with a
//   half period of BLINK_HALF cycles; otherwise led_fail is steady low.
// ---------------------------------------------------------------------------
module infer_check_ctrl #(
    parameter logic [79:0] GOLDEN         = 80'h1D471500200000B00037,
    parameter int unsigned HOLD_CYCLES    = 75000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned BLINK_HALF     = 12500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    infer_check_ctrl_if.master  net,
    output logic                led_pass,
    output logic                led_fail,
    output logic                last_timeout,
    output logic [15:0]         pass_cnt,
    output logic [15:0]         fail_cnt
);

    // One shared timer serves WAIT, SHOW and GAP (and the blink counter
    // reuses the same width), so size it for the largest terminal count.
    localparam int unsigned M1   = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned M2   = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
    localparam int unsigned TMAX = (M2 > BLINK_HALF) ? M2 : BLINK_HALF;
    localparam int unsigned TW   = $clog2(TMAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CHECK,
        S_SHOW,
        S_GAP
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [79:0]   captured, captured_nxt;
    logic          result_fail, result_fail_nxt;
    logic          net_start_nxt;
    logic          led_pass_nxt, led_fail_nxt;
    logic          last_timeout_nxt;
    logic [15:0]   pass_cnt_nxt, fail_cnt_nxt;
`ifdef FAIL_BLINK_EN
    logic [TW-1:0] blink_cnt, blink_cnt_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            timer         <= '0;
            captured      <= '0;
            result_fail   <= 1'b0;
            net.net_start <= 1'b0;
            led_pass      <= 1'b1;
            led_fail      <= 1'b1;
            last_timeout  <= 1'b0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
`ifdef FAIL_BLINK_EN
            blink_cnt     <= '0;
`endif
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            captured      <= captured_nxt;
            result_fail   <= result_fail_nxt;
            net.net_start <= net_start_nxt;
            led_pass      <= led_pass_nxt;
            led_fail      <= led_fail_nxt;
            last_timeout  <= last_timeout_nxt;
            pass_cnt      <= pass_cnt_nxt;
            fail_cnt      <= fail_cnt_nxt;
`ifdef FAIL_BLINK_EN
            blink_cnt     <= blink_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt        = state;
        timer_nxt        = timer;
        captured_nxt     = captured;
        result_fail_nxt  = result_fail;
        last_timeout_nxt = last_timeout;
        pass_cnt_nxt     = pass_cnt;
        fail_cnt_nxt     = fail_cnt;

        case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_START;
            end
            S_START: begin
                timer_nxt = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the expiry cycle takes priority over timeout.
                if (net.net_done) begin
                    captured_nxt = net.net_dout;
                    state_nxt    = S_CHECK;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    result_fail_nxt  = 1'b1;
                    last_timeout_nxt = 1'b1;
                    if (fail_cnt != '1) fail_cnt_nxt = fail_cnt + 16'd1;
                    timer_nxt        = '0;
                    state_nxt        = S_SHOW;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_CHECK: begin
                if (captured == GOLDEN) begin
                    result_fail_nxt = 1'b0;
                    if (pass_cnt != '1) pass_cnt_nxt = pass_cnt + 16'd1;
                end else begin
                    result_fail_nxt = 1'b1;
                    if (fail_cnt != '1) fail_cnt_nxt = fail_cnt + 16'd1;
                end
                last_timeout_nxt = 1'b0;
                timer_nxt        = '0;
                state_nxt        = S_SHOW;
            end
            S_SHOW: begin
                if (timer == TW'(HOLD_CYCLES - 1)) begin
                    timer_nxt = '0;
                    state_nxt = S_GAP;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_GAP: begin
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    timer_nxt = '0;
                    state_nxt = enable ? S_START : S_IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up exactly
        // with the cycles spent in START/SHOW.
        net_start_nxt = (state_nxt == S_START);
        led_pass_nxt  = ~((state_nxt == S_SHOW) && !result_fail_nxt);

`ifdef FAIL_BLINK_EN
        blink_cnt_nxt = '0;
        led_fail_nxt  = 1'b1;
        if ((state_nxt == S_SHOW) && result_fail_nxt) begin
            if (state != S_SHOW) begin
                led_fail_nxt = 1'b0;
            end else if (blink_cnt == TW'(BLINK_HALF - 1)) begin
                led_fail_nxt = ~led_fail;
            end else begin
                led_fail_nxt  = led_fail;
                blink_cnt_nxt = blink_cnt + 1'b1;
            end
        end
`else
        led_fail_nxt  = ~((state_nxt == S_SHOW) && result_fail_nxt);
`endif
    end

endmodule

// File: tb/tb_infer_check_ctrl.sv
// ---------------------------------------------------------------------------
// tb_infer_check_ctrl
//   Self-checking bench for infer_check_ctrl with short timing parameters.
//   A table of network responses is replayed; expected run outcomes go into a
//   scoreboard queue when the response is driven and are popped when the LEDs
//   show a result. Hand-written sequences cover enable drop, reset in SHOW,
//   late completions and counter saturation.
// ---------------------------------------------------------------------------
module tb_infer_check_ctrl;

    localparam int unsigned HOLD  = 20;
    localparam int unsigned TMO   = 50;
    localparam int unsigned GAP   = 5;
    localparam int unsigned BLINK = 4;
    localparam logic [79:0] GOLD  = 80'h1D471500200000B00037;

    typedef struct {
        int          delay;   // cycles from START to net_done; <0 = never
        logic [79:0] dout;
    } vec_t;

    typedef struct {
        bit          fail;
        bit          to;
        int          lat;
        logic [15:0] pc;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        led_pass, led_fail, last_timeout;
    logic [15:0] pass_cnt, fail_cnt;

    int          checks = 0;
    int          errors = 0;
    int          starts = 0;
    logic [15:0] exp_pc = '0;
    logic [15:0] exp_fc = '0;
    exp_t        sb[$];
    vec_t        vt[7];

    infer_check_ctrl_if nif();

    infer_check_ctrl #(
        .GOLDEN         (GOLD),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP),
        .BLINK_HALF     (BLINK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .net          (nif),
        .led_pass     (led_pass),
        .led_fail     (led_fail),
        .last_timeout (last_timeout),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (nif.net_start === 1'b1) starts <= starts + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_fail_led(input int k);
`ifdef FAIL_BLINK_EN
        return ((k / BLINK) % 2) != 0;
`else
        return (k < 0);
`endif
    endfunction

    task automatic wait_start(output int w);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (nif.net_start !== 1'b1 && w < 100);
    endtask

    task automatic bump(input bit fail);
        if (fail) begin
            if (exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
        end else begin
            if (exp_pc != 16'hFFFF) exp_pc = exp_pc + 16'd1;
        end
    endtask

    task automatic run_vec(input vec_t v, input int exp_wait, input bit drop);
        int   w;
        int   d;
        int   n;
        bit   to;
        exp_t e;
        wait_start(w);
        chk("start_wait", w, exp_wait);
        if (nif.net_start !== 1'b1) return;
        to = (v.delay < 0);
        d  = to ? TMO : v.delay;
        for (int c = 1; c <= d; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("start_pulse_width", nif.net_start, 0);
                if (drop) enable = 1'b0;
            end
        end
        if (!to) begin
            nif.net_done = 1'b1;
            nif.net_dout = v.dout;
        end
        e.fail = to || (v.dout != GOLD);
        e.to   = to;
        e.lat  = to ? 1 : 2;
        bump(e.fail);
        e.pc   = exp_pc;
        e.fc   = exp_fc;
        sb.push_back(e);

        n = 1;
        @(negedge clk);
        nif.net_done = 1'b0;
        while (led_pass === 1'b1 && led_fail === 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk("show_latency", n, e.lat);
        for (int k = 0; k < int'(HOLD); k++) begin
            chk($sformatf("show_leds[%0d]", k), {led_pass, led_fail},
                e.fail ? {1'b1, exp_fail_led(k)} : 2'b01);
            @(negedge clk);
        end
        chk("gap_leds", {led_pass, led_fail}, 2'b11);
        chk("last_timeout", last_timeout, e.to);
        chk("pass_cnt", pass_cnt, e.pc);
        chk("fail_cnt", fail_cnt, e.fc);
    endtask

    initial begin
        int w;
        int s0;
        vt[0] = '{delay: 10, dout: GOLD};
        vt[1] = '{delay: 10, dout: GOLD ^ 80'h1};
        vt[2] = '{delay: -1, dout: GOLD};
        vt[3] = '{delay: 50, dout: GOLD};
        vt[4] = '{delay: 49, dout: GOLD ^ {1'b1, 79'b0}};
        vt[5] = '{delay: 1,  dout: GOLD};
        vt[6] = '{delay: 10, dout: 80'h0};

        nif.net_done = 1'b0;
        nif.net_dout = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_leds", {led_pass, led_fail}, 2'b11);
        chk("rst_net_start", nif.net_start, 0);
        chk("rst_last_timeout", last_timeout, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back table runs; the last one drops enable mid-run.
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_vec(vt[i], (i == 0) ? 1 : GAP, i == 6);
        end
        s0 = starts;
        repeat (40) @(negedge clk);
        chk("no_start_after_drop", starts, s0);

        // Completion while idle must not count.
        nif.net_done = 1'b1;
        nif.net_dout = GOLD;
        @(negedge clk);
        nif.net_done = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_done_pass_cnt", pass_cnt, exp_pc);
        chk("idle_done_fail_cnt", fail_cnt, exp_fc);
        chk("idle_done_start", starts, s0);

        // Reset in the middle of SHOW.
        enable = 1'b1;
        wait_start(w);
        chk("idle_to_start", w, 1);
        repeat (10) @(negedge clk);
        nif.net_done = 1'b1;
        nif.net_dout = GOLD;
        @(negedge clk);
        nif.net_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_led_pass", led_pass, 0);
        rst_n  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("mid_rst_leds", {led_pass, led_fail}, 2'b11);
        chk("mid_rst_pass_cnt", pass_cnt, 0);
        chk("mid_rst_fail_cnt", fail_cnt, 0);
        chk("mid_rst_last_timeout", last_timeout, 0);
        chk("mid_rst_net_start", nif.net_start, 0);
        rst_n  = 1'b1;
        exp_pc = '0;
        exp_fc = '0;
        repeat (3) @(negedge clk);
        nif.net_done = 1'b1;
        nif.net_dout = GOLD;
        @(negedge clk);
        nif.net_done = 1'b0;
        s0 = starts;
        repeat (20) @(negedge clk);
        chk("late_done_start", starts, s0);
        chk("late_done_pass_cnt", pass_cnt, 0);
        chk("late_done_leds", {led_pass, led_fail}, 2'b11);

        // Back in IDLE: a fresh run starts one cycle after enable.
        enable = 1'b1;
        run_vec(vt[0], 1, 1);
        repeat (30) @(negedge clk);

        // Saturation of pass_cnt.
        force dut.pass_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.pass_cnt;
        @(negedge clk);
        chk("forced_pass_cnt", pass_cnt, 16'hFFFE);
        exp_pc = 16'hFFFE;
        enable = 1'b1;
        run_vec(vt[0], 1, 0);
        run_vec(vt[5], GAP, 1);
        repeat (10) @(negedge clk);
        chk("sat_pass_cnt", pass_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
